// File: rtl/ps_header_extractor.sv
// +----------------------------------------------------------------------------+
// | ps_header_extractor: strips HWORDS header words per packet onto o_param    |
// | and passes the payload through with zero latency.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ps_header_extractor #(
  parameter int DWIDTH = 8,
  parameter int HWORDS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DWIDTH-1:0]        i_dat,
  input  logic                     i_val,
  input  logic                     i_eop,
  output logic                     i_rdy,
  output logic [DWIDTH-1:0]        o_dat,
  output logic                     o_val,
  output logic                     o_eop,
  input  logic                     o_rdy,
  output logic [DWIDTH*HWORDS-1:0] o_param,
  output logic                     o_upd,
  output logic                     o_err
);

  localparam int PWIDTH = DWIDTH * HWORDS;
  localparam int CW     = (HWORDS > 1) ? $clog2(HWORDS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(HWORDS - 1);

  typedef enum logic [0:0] {
    ST_HEADER  = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [PWIDTH-1:0]   r_shadow;
  logic [PWIDTH-1:0]   r_param;
  logic                r_upd;
  logic                r_err;
  logic [PWIDTH-1:0]   w_shadow_next;
  logic                w_payload;

  // Outputs are forced to the header-state view while reset is held.
  assign w_payload = (r_state == ST_PAYLOAD) && !reset;

  assign i_rdy   = w_payload ? o_rdy : 1'b1;
  assign o_dat   = i_dat;
  assign o_val   = w_payload && i_val;
  assign o_eop   = w_payload && i_eop;
  assign o_param = r_param;
  assign o_upd   = r_upd;
  assign o_err   = r_err;

  // Shadow value including the word currently presented, so the last
  // header word can be committed to o_param on the same edge.
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[r_cnt*DWIDTH +: DWIDTH] = i_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_HEADER;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_param  <= '0;
      r_upd    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_HEADER: begin
          if (i_val) begin
            r_shadow <= w_shadow_next;
            if (i_eop) begin
              r_err <= 1'b1;
              r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
              r_param <= w_shadow_next;
              r_upd   <= 1'b1;
              r_state <= ST_PAYLOAD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_PAYLOAD: begin
          if (i_val && o_rdy && i_eop) begin
            r_state <= ST_HEADER;
          end
        end
        default: r_state <= ST_HEADER;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps_header_extractor.sv
// +----------------------------------------------------------------------------+
// | tb_ps_header_extractor: directed vectors for HWORDS=2 and HWORDS=1.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ps_header_extractor;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_dat;
  logic        i_val, i_eop, o_rdy;
  logic        i_rdy, o_val, o_eop, o_upd, o_err;
  logic [7:0]  o_dat;
  logic [15:0] o_param;

  logic [7:0]  a_dat;
  logic        a_val, a_eop, a_ordy;
  logic        a_rdy, a_oval, a_oeop, a_upd, a_err;
  logic [7:0]  a_odat;
  logic [7:0]  a_param;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ps_header_extractor #(.DWIDTH(8), .HWORDS(2)) u_dut (
    .clk(clk), .reset(reset),
    .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
    .o_param(o_param), .o_upd(o_upd), .o_err(o_err)
  );

  ps_header_extractor #(.DWIDTH(8), .HWORDS(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_dat(a_dat), .i_val(a_val), .i_eop(a_eop), .i_rdy(a_rdy),
    .o_dat(a_odat), .o_val(a_oval), .o_eop(a_oeop), .o_rdy(a_ordy),
    .o_param(a_param), .o_upd(a_upd), .o_err(a_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One cycle on the HWORDS=2 instance: comb outputs before the edge,
  // registered outputs just after it.
  task automatic cyc(input string tag, input logic [7:0] d, input logic v, input logic e,
                     input logic ordy, input logic x_rdy, input logic x_val, input logic x_eop,
                     input logic x_upd, input logic x_err, input logic [15:0] x_param);
    i_dat = d; i_val = v; i_eop = e; o_rdy = ordy;
    #2;
    chk({tag, ".i_rdy"}, 32'(i_rdy), 32'(x_rdy));
    chk({tag, ".o_val"}, 32'(o_val), 32'(x_val));
    chk({tag, ".o_eop"}, 32'(o_eop), 32'(x_eop));
    if (x_val) chk({tag, ".o_dat"}, 32'(o_dat), 32'(d));
    @(posedge clk); #1;
    chk({tag, ".o_upd"}, 32'(o_upd), 32'(x_upd));
    chk({tag, ".o_err"}, 32'(o_err), 32'(x_err));
    chk({tag, ".o_param"}, 32'(o_param), 32'(x_param));
  endtask

  initial begin
    reset = 1'b1;
    i_dat = '0; i_val = 1'b1; i_eop = 1'b0; o_rdy = 1'b1;
    a_dat = '0; a_val = 1'b0; a_eop = 1'b0; a_ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.o_param", 32'(o_param), 32'h0);
    chk("rst.o_upd", 32'(o_upd), 32'h0);
    chk("rst.o_err", 32'(o_err), 32'h0);
    chk("rst.i_rdy", 32'(i_rdy), 32'h1);
    chk("rst.o_val", 32'(o_val), 32'h0);
    chk("rst.a_param", 32'(a_param), 32'h0);
    reset = 1'b0;
    i_val = 1'b0;

    // Nominal packet
    cyc("nom0", 8'h34, 1, 0, 1, 1, 0, 0, 0, 0, 16'h0000);
    cyc("nom1", 8'h12, 1, 0, 1, 1, 0, 0, 1, 0, 16'h1234);
    cyc("nom2", 8'hA0, 1, 0, 1, 1, 1, 0, 0, 0, 16'h1234);
    cyc("nom3", 8'hA1, 1, 0, 1, 1, 1, 0, 0, 0, 16'h1234);
    cyc("nom4", 8'hA2, 1, 1, 1, 1, 1, 1, 0, 0, 16'h1234);
    cyc("idle", 8'h00, 0, 0, 1, 1, 0, 0, 0, 0, 16'h1234);

    // Backpressure, o_rdy toggling
    cyc("bp0", 8'h34, 1, 0, 1, 1, 0, 0, 0, 0, 16'h1234);
    cyc("bp1", 8'h12, 1, 0, 0, 1, 0, 0, 1, 0, 16'h1234);
    cyc("bp2", 8'hA0, 1, 0, 1, 1, 1, 0, 0, 0, 16'h1234);
    cyc("bp3", 8'hA1, 1, 0, 0, 0, 1, 0, 0, 0, 16'h1234);
    cyc("bp4", 8'hA1, 1, 0, 1, 1, 1, 0, 0, 0, 16'h1234);
    cyc("bp5", 8'hA2, 1, 1, 0, 0, 1, 1, 0, 0, 16'h1234);
    cyc("bp6", 8'hA2, 1, 1, 1, 1, 1, 1, 0, 0, 16'h1234);

    // Short and header-only packets
    cyc("sh0", 8'h55, 1, 1, 1, 1, 0, 0, 0, 1, 16'h1234);
    cyc("sh1", 8'h66, 1, 0, 1, 1, 0, 0, 0, 0, 16'h1234);
    cyc("sh2", 8'h77, 1, 1, 1, 1, 0, 0, 0, 1, 16'h1234);
    cyc("sh3", 8'h00, 0, 0, 1, 1, 0, 0, 0, 0, 16'h1234);

    // Back-to-back packets, i_val held high
    cyc("bb0", 8'h34, 1, 0, 1, 1, 0, 0, 0, 0, 16'h1234);
    cyc("bb1", 8'h12, 1, 0, 1, 1, 0, 0, 1, 0, 16'h1234);
    cyc("bb2", 8'hB0, 1, 1, 1, 1, 1, 1, 0, 0, 16'h1234);
    cyc("bb3", 8'hEF, 1, 0, 1, 1, 0, 0, 0, 0, 16'h1234);
    cyc("bb4", 8'hBE, 1, 0, 1, 1, 0, 0, 1, 0, 16'hBEEF);
    cyc("bb5", 8'hC0, 1, 1, 1, 1, 1, 1, 0, 0, 16'hBEEF);

    // Reset mid-payload
    cyc("rm0", 8'h34, 1, 0, 1, 1, 0, 0, 0, 0, 16'hBEEF);
    cyc("rm1", 8'h12, 1, 0, 1, 1, 0, 0, 1, 0, 16'h1234);
    cyc("rm2", 8'hA0, 1, 0, 1, 1, 1, 0, 0, 0, 16'h1234);
    reset = 1'b1;
    cyc("rmR", 8'hA1, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
    reset = 1'b0;
    cyc("rm3", 8'hA1, 1, 0, 1, 1, 0, 0, 0, 0, 16'h0000);
    cyc("rm4", 8'hA2, 1, 1, 1, 1, 0, 0, 0, 1, 16'h0000);
    i_val = 1'b0;

    // HWORDS = 1 instance
    a_dat = 8'h09; a_val = 1'b1; a_eop = 1'b1;
    #2;
    chk("h1a.o_val", 32'(a_oval), 32'h0);
    @(posedge clk); #1;
    chk("h1a.o_err", 32'(a_err), 32'h1);
    chk("h1a.o_upd", 32'(a_upd), 32'h0);
    a_dat = 8'h07; a_eop = 1'b0;
    @(posedge clk); #1;
    chk("h1b.o_upd", 32'(a_upd), 32'h1);
    chk("h1b.o_err", 32'(a_err), 32'h0);
    chk("h1b.o_param", 32'(a_param), 32'h07);
    a_dat = 8'h08; a_eop = 1'b1;
    #2;
    chk("h1c.o_val", 32'(a_oval), 32'h1);
    chk("h1c.o_dat", 32'(a_odat), 32'h08);
    chk("h1c.o_eop", 32'(a_oeop), 32'h1);
    @(posedge clk); #1;
    chk("h1c.o_upd", 32'(a_upd), 32'h0);
    chk("h1c.o_param", 32'(a_param), 32'h07);
    a_val = 1'b0; a_eop = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
